// File: rtl/d_driver.sv
// d_driver: SD 4-bit DAT-line driver for single-block reads and writes with per-line CRC16.
// Define D_DRIVER_TIMEOUT_EN to bound the R_WAIT, W_STAT and W_BUSY waits by TIMEOUT cycles.
module d_driver #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [3:0]        idata_sd,
  output logic [3:0]        odata_sd,
  input  logic              istart_read,
  input  logic              istart_write,
  output logic [ADDR_W-1:0] oaddr,
  output logic [3:0]        owdata,
  output logic              owrite_en,
  input  logic [3:0]        irdata,
  output logic              ocrc_fail,
  output logic              odone
);

  typedef enum logic [3:0] {
    IDLE, R_WAIT, R_DATA, R_CRC, R_END,
    W_PRE, W_START, W_DATA, W_CRC, W_END, W_STAT, W_BUSY,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] DATA_LAST = '1;
  localparam logic [ADDR_W-1:0] CRC_LAST  = ADDR_W'(15);

  if (ADDR_W < 4) begin : g_bad_addr_w
    $error("d_driver: ADDR_W must be at least 4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("d_driver: TIMEOUT must fit the 16-bit wait counter");
  end

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [3:0][15:0]  crc;
  logic [2:0]        tok_cnt;
  logic [2:0]        status;
  logic              tmo_hit;
  logic              tmo_abort;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

`ifdef D_DRIVER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt;
  logic        in_wait;

  assign in_wait = (state == R_WAIT) || (state == W_STAT) || (state == W_BUSY);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst)                    tmo_cnt <= '0;
    else if (next_state != state) tmo_cnt <= '0;
    else if (in_wait)             tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = in_wait && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    next_state = state;
    tmo_abort  = 1'b0;
    odone      = 1'b0;
    unique case (state)
      IDLE: begin
        if (istart_read)       next_state = R_WAIT;
        else if (istart_write) next_state = W_PRE;
      end
      R_WAIT: begin
        if (idata_sd == 4'h0) next_state = R_DATA;
        else if (tmo_hit)     tmo_abort  = 1'b1;
      end
      R_DATA:  if (cnt == DATA_LAST) next_state = R_CRC;
      R_CRC:   if (cnt == CRC_LAST)  next_state = R_END;
      R_END:   next_state = DONE;
      W_PRE:   next_state = W_START;
      W_START: next_state = W_DATA;
      W_DATA:  if (cnt == DATA_LAST) next_state = W_CRC;
      W_CRC:   if (cnt == CRC_LAST)  next_state = W_END;
      W_END:   next_state = W_STAT;
      W_STAT: begin
        if (tok_cnt == 3'd4) next_state = W_BUSY;
        else if (tmo_hit)    tmo_abort  = 1'b1;
      end
      W_BUSY: begin
        if (idata_sd[0])  next_state = DONE;
        else if (tmo_hit) tmo_abort  = 1'b1;
      end
      DONE: begin
        odone      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (tmo_abort) next_state = DONE;
  end

  // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      cnt       <= '0;
      crc       <= '0;
      tok_cnt   <= '0;
      status    <= '0;
      odata_sd  <= 4'hF;
      oaddr     <= '0;
      owdata    <= '0;
      owrite_en <= 1'b0;
      ocrc_fail <= 1'b0;
    end else begin
      cnt       <= (next_state != state) ? '0 : cnt + ADDR_W'(1);
      owrite_en <= 1'b0;
      odata_sd  <= 4'hF;
      if (tmo_abort) ocrc_fail <= 1'b1;

      case (state)
        IDLE: begin
          if (istart_read || istart_write) begin
            crc       <= '0;
            ocrc_fail <= 1'b0;
            oaddr     <= '0;
            tok_cnt   <= '0;
          end
        end
        R_DATA: begin
          owdata    <= idata_sd;
          oaddr     <= cnt;
          owrite_en <= 1'b1;
          for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], idata_sd[i]);
        end
        // Feeding the received CRC through the same LFSR leaves zero when it matches.
        R_CRC:   for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], idata_sd[i]);
        R_END:   ocrc_fail <= (crc != '0) || (idata_sd != 4'hF);
        W_PRE, W_START, W_DATA: oaddr <= oaddr + ADDR_W'(1);
        W_STAT: begin
          if (tok_cnt == 3'd0) begin
            if (!idata_sd[0]) tok_cnt <= 3'd1;
          end else if (tok_cnt != 3'd4) begin
            status  <= {status[1:0], idata_sd[0]};
            tok_cnt <= tok_cnt + 3'd1;
          end else begin
            ocrc_fail <= (status != 3'b010);
          end
        end
        default: ;
      endcase

      // The bus is registered, so the write path is keyed on the state being entered.
      case (next_state)
        W_START: odata_sd <= 4'h0;
        W_DATA: begin
          odata_sd <= irdata;
          for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], irdata[i]);
        end
        W_CRC: begin
          for (int i = 0; i < 4; i++) begin
            odata_sd[i] <= crc[i][15];
            crc[i]      <= {crc[i][14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_driver.sv
// tb_d_driver: directed sequence of reads/writes with random block data, checked against
// a polynomial-division CRC model and a card/RAM model kept in the bench.
module tb_d_driver;
  localparam int ADDR_W = 10;
  localparam int N      = 1 << ADDR_W;

  logic              iclk = 1'b0;
  logic              irst;
  logic [3:0]        idata_sd = 4'hF;
  logic [3:0]        odata_sd;
  logic              istart_read = 1'b0;
  logic              istart_write = 1'b0;
  logic [ADDR_W-1:0] oaddr;
  logic [3:0]        owdata;
  logic              owrite_en;
  logic [3:0]        irdata;
  logic              ocrc_fail;
  logic              odone;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [3:0] mem [N];
  logic [3:0] blk [N];

  logic [3:0] bus_q [$];
  int         wr_n, wr_bad, first_wr_cyc, done_n, done_cyc;
  logic       done_fail;

  d_driver #(.ADDR_W(ADDR_W)) dut (
    .iclk(iclk), .irst(irst), .idata_sd(idata_sd), .odata_sd(odata_sd),
    .istart_read(istart_read), .istart_write(istart_write),
    .oaddr(oaddr), .owdata(owdata), .owrite_en(owrite_en), .irdata(irdata),
    .ocrc_fail(ocrc_fail), .odone(odone)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) irdata <= mem[oaddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of line(x) * x^16 divided by x^16+x^12+x^5+1, first bus bit as the MSB.
  function automatic logic [15:0] ref_crc(input int line);
    logic        msg [N+16];
    logic [16:0] poly;
    logic [15:0] r;
    poly = 17'h11021;
    for (int i = 0; i < N + 16; i++) msg[i] = (i < N) ? blk[i][line] : 1'b0;
    for (int i = 0; i < N; i++)
      if (msg[i])
        for (int j = 0; j < 17; j++) msg[i+j] = msg[i+j] ^ poly[16-j];
    r = '0;
    for (int j = 0; j < 16; j++) r = {r[14:0], msg[N+j]};
    return r;
  endfunction

  task automatic clear_log();
    bus_q.delete();
    wr_n = 0; wr_bad = 0; first_wr_cyc = -1;
    done_n = 0; done_cyc = -1; done_fail = 1'bx;
  endtask

  task automatic tick();
    @(negedge iclk);
    cyc++;
    bus_q.push_back(odata_sd);
    if (owrite_en) begin
      if (wr_n == 0) first_wr_cyc = cyc;
      if (wr_n >= N || oaddr !== ADDR_W'(wr_n) || owdata !== blk[wr_n]) wr_bad++;
      wr_n++;
    end
    if (odone) begin
      done_n++;
      done_cyc  = cyc;
      done_fail = ocrc_fail;
    end
  endtask

  task automatic do_read(input int flip_line, input logic [3:0] end_nib, input logic both,
                         input logic exp_fail);
    logic [15:0] crc [4];
    int t0, bad;
    for (int l = 0; l < 4; l++) crc[l] = ref_crc(l);
    if (flip_line >= 0) crc[flip_line][0] = ~crc[flip_line][0];
    clear_log();
    istart_read = 1'b1; istart_write = both; tick();
    istart_read = 1'b0; istart_write = 1'b0;
    check("rd_fail_clr", ocrc_fail, 1'b0);
    repeat ($urandom_range(0, 5)) begin idata_sd = 4'hF; tick(); end
    t0 = cyc; idata_sd = 4'h0; tick();
    for (int k = 0; k < N; k++) begin
      idata_sd = blk[k]; istart_write = (k == 500); tick();
    end
    istart_write = 1'b0;
    for (int j = 0; j < 16; j++) begin
      idata_sd = {crc[3][15-j], crc[2][15-j], crc[1][15-j], crc[0][15-j]}; tick();
    end
    idata_sd = end_nib; tick();
    idata_sd = 4'hF;
    for (int i = 0; i < 8 && done_n == 0; i++) tick();
    repeat (2) tick();
    check("rd_writes",   wr_n, N);
    check("rd_wdata",    wr_bad, 0);
    check("rd_first_wr", first_wr_cyc, t0 + 2);
    check("rd_done_n",   done_n, 1);
    check("rd_done_cyc", done_cyc, t0 + 1042);
    check("rd_fail",     done_fail, exp_fail);
    bad = 0;
    foreach (bus_q[i]) if (bus_q[i] !== 4'hF) bad++;
    check("rd_bus_idle", bad, 0);
  endtask

  task automatic do_write(input logic [2:0] stat, input int busy, input logic exp_fail);
    logic [15:0] crc [4];
    logic [3:0]  nib;
    int ts, bad;
    for (int k = 0; k < N; k++) mem[k] = blk[k];
    for (int l = 0; l < 4; l++) crc[l] = ref_crc(l);
    clear_log();
    istart_write = 1'b1; tick(); istart_write = 1'b0;
    check("wr_fail_clr", ocrc_fail, 1'b0);
    for (int i = 0; i < 1042; i++) begin istart_read = (i == 300); tick(); end
    istart_read = 1'b0;
    check("wr_pre",   bus_q[0], 4'hF);
    check("wr_start", bus_q[1], 4'h0);
    bad = 0;
    for (int k = 0; k < N; k++) if (bus_q[2+k] !== blk[k]) bad++;
    check("wr_data", bad, 0);
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      nib = {crc[3][15-j], crc[2][15-j], crc[1][15-j], crc[0][15-j]};
      if (bus_q[N+2+j] !== nib) bad++;
    end
    check("wr_crc", bad, 0);
    check("wr_end", bus_q[N+18], 4'hF);
    repeat (1 + $urandom_range(0, 3)) begin idata_sd = 4'hF; tick(); end
    ts = cyc; idata_sd = 4'hE; tick();
    for (int b = 2; b >= 0; b--) begin idata_sd = {3'b111, stat[b]}; tick(); end
    idata_sd = 4'hF; tick();
    repeat (busy) begin idata_sd = 4'hE; tick(); end
    idata_sd = 4'hF; tick();
    for (int i = 0; i < 8 && done_n == 0; i++) tick();
    repeat (2) tick();
    check("wr_done_n",   done_n, 1);
    check("wr_done_cyc", done_cyc, ts + 6 + busy);
    check("wr_fail",     done_fail, exp_fail);
    check("wr_no_strobe", wr_n, 0);
    bad = 0;
    for (int i = N + 19; i < bus_q.size(); i++) if (bus_q[i] !== 4'hF) bad++;
    check("wr_release", bad, 0);
  endtask

  task automatic rand_blk();
    for (int k = 0; k < N; k++) blk[k] = 4'($urandom);
  endtask

  initial begin
    irst = 1'b1;
    #1 irst = 1'b0;
    #1;
    check("rst_odata",  odata_sd, 4'hF);
    check("rst_oaddr",  oaddr, '0);
    check("rst_owdata", owdata, 4'h0);
    check("rst_wen",    owrite_en, 1'b0);
    check("rst_fail",   ocrc_fail, 1'b0);
    check("rst_done",   odone, 1'b0);
    repeat (2) @(negedge iclk);
    irst = 1'b1;

    for (int k = 0; k < N; k++) blk[k] = 4'(k);
    do_read(-1, 4'hF, 1'b0, 1'b0);
    do_read(2, 4'hF, 1'b0, 1'b1);
    rand_blk();
    do_read(-1, 4'hF, 1'b1, 1'b0);
    do_read(-1, 4'h7, 1'b0, 1'b1);

    clear_log();
    istart_read = 1'b1; tick(); istart_read = 1'b0;
    idata_sd = 4'h0; tick();
    for (int k = 0; k < 100; k++) begin idata_sd = blk[k]; tick(); end
    check("mid_strobe", owrite_en, 1'b1);
    #2 irst = 1'b0;
    #1;
    check("abort_odata", odata_sd, 4'hF);
    check("abort_wen",   owrite_en, 1'b0);
    check("abort_done",  odone, 1'b0);
    check("abort_oaddr", oaddr, '0);
    idata_sd = 4'hF;
    @(negedge iclk);
    irst = 1'b1;
    clear_log();
    repeat (4) tick();
    check("abort_no_done",   done_n, 0);
    check("abort_no_strobe", wr_n, 0);
    rand_blk();
    do_read(-1, 4'hF, 1'b0, 1'b0);

    for (int k = 0; k < N; k++) blk[k] = 4'hA;
    do_write(3'b010, 5, 1'b0);
    rand_blk();
    do_write(3'b101, 2, 1'b1);
    rand_blk();
    do_write(3'b010, $urandom_range(0, 6), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/d_driver.md
Name: d_driver

Overview:
- SD-bus 4-bit DAT-line driver for single 512-byte block transfers (1024 nibbles) between the card and a local nibble buffer.
- Read: receives a block from the card, writes it into the buffer and checks the per-line CRC16.
- Write: streams a block from the buffer to the card with CRC16, then collects the card's CRC-status token and busy.
- Sits between the SD transceiver pads and the block buffer RAM, under the command-level controller.

Parameters:
- ADDR_W, 10, buffer address width; block length = 2**ADDR_W nibbles.
- TIMEOUT, 65535, cycle limit used only when D_DRIVER_TIMEOUT_EN is defined.

Ports:
- iclk  in  1  system/SD clock; all logic on the rising edge.
- irst  in  1  reset, asynchronous, active-low.
- idata_sd  in  4  DAT[3:0] from the card, sampled on the rising edge.
- odata_sd  out  4  DAT[3:0] to the card; 4'hF whenever not transmitting.
- istart_read  in  1  one-cycle pulse that starts a block read.
- istart_write  in  1  one-cycle pulse that starts a block write.
- oaddr  out  ADDR_W  buffer nibble address.
- owdata  out  4  nibble to the buffer.
- owrite_en  out  1  buffer write strobe.
- irdata  in  4  buffer read data; synchronous RAM, valid one cycle after oaddr.
- ocrc_fail  out  1  transfer error flag; valid with odone, held until the next start.
- odone  out  1  one-cycle completion pulse.

Behaviour:
- Reset (irst=0, asynchronous): state IDLE, odata_sd=4'hF, oaddr=0, owdata=0, owrite_en=0, ocrc_fail=0, odone=0, CRCs cleared. Reset mid-transfer aborts with no odone.
- Start pulses:
  - Start pulses are ignored outside IDLE.
  - If istart_read and istart_write arrive together, read wins.
  - Any start clears ocrc_fail.
- Nibble mapping:
  - Buffer address k holds the k-th nibble on the bus; each byte goes high nibble first.
  - DAT3 carries the nibble's bit 3 … DAT0 carries bit 0.
- CRC:
  - One independent CRC16-CCITT per line (x^16+x^12+x^5+1), initial value 0.
  - Computed over that line's 1024 data bits; CRC is sent/received MSB first, 16 cycles.
- Read FSM: IDLE -> R_WAIT -> R_DATA -> R_CRC -> R_END -> DONE.
  - R_WAIT: wait until idata_sd==4'h0 (start bit).
  - R_DATA: 1024 cycles. Nibble sampled in cycle k is registered to owdata, with oaddr=k and owrite_en=1 in cycle k+1. owrite_en is high for exactly 1024 cycles.
  - R_CRC: 16 cycles; shift the received CRC bits per line.
  - R_END: expect 4'hF. ocrc_fail=1 if any line's received CRC differs from the computed CRC, or if the end bit is not 4'hF.
- Write FSM: IDLE -> W_PRE -> W_START -> W_DATA -> W_CRC -> W_END -> W_STAT -> W_BUSY -> DONE.
  - W_PRE: odata_sd=F for one cycle, oaddr=0.
  - W_START: odata_sd=0, oaddr=1.
  - W_DATA: drive irdata for 1024 cycles; oaddr runs one ahead and wraps without effect.
  - W_CRC: drive the 16 CRC bits per line.
  - W_END: drive 4'hF, then release the bus (F).
  - W_STAT: wait for DAT0=0 (token start). Sample the next 3 bits as status, then the end bit. Status 3'b010 = accepted; any other status sets ocrc_fail.
  - W_BUSY: wait while DAT0=0; exit on DAT0=1.
- DONE: odone=1 for one cycle, then IDLE. owrite_en is never asserted during a write.
- Without D_DRIVER_TIMEOUT_EN, the driver waits indefinitely in R_WAIT, W_STAT and W_BUSY.

Optional Feature:
- Macro D_DRIVER_TIMEOUT_EN.
- When defined: a 16-bit counter runs in R_WAIT, W_STAT and W_BUSY. After TIMEOUT cycles the FSM goes to DONE with ocrc_fail=1.
- When undefined: no counter is synthesized, and the waits are unbounded.

Test Plan:
- Reset: irst=0 mid-R_DATA -> odata_sd=F, owrite_en=0, odone=0 immediately; after release, IDLE accepts a new start.
- Read, good block: start_read, card sends 0000, nibbles k&4'hF for k=0..1023, the correct per-line CRCs, then 1111 -> 1024 writes with oaddr=k, owdata=k[3:0]; odone pulse with ocrc_fail=0.
- Read, bad CRC: same block with bit 0 of DAT2's CRC flipped -> odone with ocrc_fail=1.
- Write, accepted: buffer = all 4'hA, start_write -> bus shows F, 0, 1024×A, correct CRCs, F. Card replies DAT0 0,0,1,0,1, then 5 cycles busy low -> odone after busy ends, ocrc_fail=0.
- Write, rejected: status 101 -> ocrc_fail=1.
- Simultaneous start_read and start_write in IDLE -> read performed; a start pulse during a transfer is ignored.
